// File: rtl/clock_step_ctrl.sv
// clock_step_ctrl
// ---------------
// Clock-enable scheduler for a pipelined CPU core. The core advances only on
// cycles where tick=1. Modes: free-run at a programmable period, single step
// from a raw pushbutton, N-tick burst, and halt. clk_slow toggles on every
// tick so the tick rate can be watched on an LED or a scope probe.
//
// Ports
//   clk          system clock (only clock)
//   rst          synchronous, active-high reset
//   run_req      level, request free-run
//   halt_req     level, highest priority, forces IDLE
//   step_req     raw asynchronous pushbutton; each rising edge asks for one tick
//   burst_start  one-cycle pulse, start a burst of burst_len ticks
//   burst_len    burst length, captured with burst_start
//   div_cfg      tick period in clk cycles, captured on entry to RUN/BURST
//   tick         registered one-cycle clock-enable pulse
//   clk_slow     toggles on every tick
//   busy         high whenever state != IDLE
//   state        IDLE=0, RUN=1, STEP=2, BURST=3
//   tick_count   ticks issued since reset, wraps silently
module clock_step_ctrl #(
  parameter int DIV_W = 16,
  parameter int LEN_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             burst_start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [DIV_W-1:0] div_cfg,
  output logic             tick,
  output logic             clk_slow,
  output logic             busy,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] tick_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BURST = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               tick_q, tick_d;
  logic               clk_slow_q, clk_slow_d;
  logic [CNT_W-1:0]   tick_count_q, tick_count_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   period_q, period_d;
  logic [LEN_W-1:0]   remain_q, remain_d;
  logic               s1_q, s2_q, s3_q;

  logic               step_edge;
  logic [DIV_W-1:0]   period_cfg;
  logic               period_hit;

  // s1 is the metastability-catching flop; the edge is taken between s2/s3
  // so a button held high produces exactly one step.
  assign step_edge  = s2_q & ~s3_q;

  // Periods of 0 and 1 both mean "tick every cycle".
  assign period_cfg = (div_cfg < DIV_W'(2)) ? DIV_W'(1) : div_cfg;
  assign period_hit = (cnt_q == (period_q - DIV_W'(1)));

  always_comb begin
    state_d      = state_q;
    tick_d       = 1'b0;
    cnt_d        = cnt_q;
    period_d     = period_q;
    remain_d     = remain_q;

    case (state_q)
      ST_IDLE: begin
        if (halt_req) begin
          state_d = ST_IDLE;
        end else if (burst_start && (burst_len != '0)) begin
          // A step edge arriving on this same edge is intentionally lost.
          state_d  = ST_BURST;
          remain_d = burst_len;
          cnt_d    = '0;
          period_d = period_cfg;
        end else if (run_req) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          period_d = period_cfg;
        end else if (step_edge) begin
          state_d = ST_STEP;
          tick_d  = 1'b1;
        end
      end

      ST_RUN: begin
        if (halt_req || !run_req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (period_hit) begin
          tick_d = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      ST_STEP: begin
        // The tick was issued on entry; halt cannot take it back.
        state_d = ST_IDLE;
      end

      ST_BURST: begin
        if (halt_req) begin
          state_d  = ST_IDLE;
          remain_d = '0;
          cnt_d    = '0;
        end else if (period_hit) begin
          tick_d   = 1'b1;
          cnt_d    = '0;
          remain_d = remain_q - LEN_W'(1);
          // Leave on the final tick's edge, so that tick is seen in IDLE.
          if (remain_q == LEN_W'(1)) begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    clk_slow_d   = tick_d ? ~clk_slow_q : clk_slow_q;
    tick_count_d = tick_d ? (tick_count_q + CNT_W'(1)) : tick_count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tick_q       <= 1'b0;
      clk_slow_q   <= 1'b0;
      tick_count_q <= '0;
      cnt_q        <= '0;
      period_q     <= DIV_W'(1);
      remain_q     <= '0;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      clk_slow_q   <= clk_slow_d;
      tick_count_q <= tick_count_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      remain_q     <= remain_d;
      s1_q         <= step_req;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
    end
  end

  assign tick       = tick_q;
  assign clk_slow   = clk_slow_q;
  assign tick_count = tick_count_q;
  assign state      = state_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Testbench for clock_step_ctrl: every cycle the expected outputs after the
// next edge are pushed to a scoreboard queue, then popped and compared #1
// after that edge.
module tb_clock_step_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_req = 1'b0;
  logic        halt_req = 1'b0;
  logic        step_req = 1'b0;
  logic        burst_start = 1'b0;
  logic [15:0] burst_len = '0;
  logic [15:0] div_cfg = '0;
  logic        tick;
  logic        clk_slow;
  logic        busy;
  logic [1:0]  state;
  logic [31:0] tick_count;

  clock_step_ctrl #(.DIV_W(16), .LEN_W(16), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .run_req    (run_req),
    .halt_req   (halt_req),
    .step_req   (step_req),
    .burst_start(burst_start),
    .burst_len  (burst_len),
    .div_cfg    (div_cfg),
    .tick       (tick),
    .clk_slow   (clk_slow),
    .busy       (busy),
    .state      (state),
    .tick_count (tick_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        tick;
    logic [1:0]  st;
    logic [31:0] cnt;
    logic        slow;
  } exp_t;

  typedef struct packed {
    logic        run;
    logic        halt;
    logic        step;
    logic        bs;
    logic [15:0] bl;
    logic [15:0] dv;
    logic        et;
    logic [1:0]  es;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        burst_tbl[17];
  int          checks = 0;
  int          errors = 0;
  int          cyc_no = 0;
  logic [31:0] m_cnt = '0;
  logic        m_slow = 1'b0;

  // Drive one cycle of inputs, queue the expected post-edge outputs, then
  // compare them against the DUT #1 after the edge.
  task automatic cyc(input logic r, input logic run, input logic halt,
                     input logic step, input logic bs, input logic [15:0] bl,
                     input logic [15:0] dv, input logic et, input logic [1:0] es,
                     input string nm);
    exp_t e;
    rst = r; run_req = run; halt_req = halt; step_req = step;
    burst_start = bs; burst_len = bl; div_cfg = dv;
    if (r) begin
      m_cnt = '0;
      m_slow = 1'b0;
    end else if (et) begin
      m_cnt = m_cnt + 32'd1;
      m_slow = ~m_slow;
    end
    exp_q.push_back('{tick: et, st: es, cnt: m_cnt, slow: m_slow});
    @(posedge clk);
    #1;
    cyc_no++;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s n=%0d: scoreboard empty", nm, cyc_no);
    end else begin
      e = exp_q.pop_front();
      if ({tick, state, busy, clk_slow, tick_count} !==
          {e.tick, e.st, (e.st != 2'd0), e.slow, e.cnt}) begin
        errors++;
        $display("FAIL %s n=%0d: got tick=%0b state=%0d busy=%0b slow=%0b count=%0d, want tick=%0b state=%0d busy=%0b slow=%0b count=%0d",
                 nm, cyc_no, tick, state, busy, clk_slow, tick_count,
                 e.tick, e.st, (e.st != 2'd0), e.slow, e.cnt);
      end else begin
        $display("%-18s n=%0d tick=%0b state=%0d count=%0d", nm, cyc_no,
                 tick, state, tick_count);
      end
    end
  endtask

  task automatic idle(input int n, input string nm);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 16'd0, 16'd0, 0, 2'd0, nm);
  endtask

  task automatic chk_val(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end else begin
      $display("%-18s value=%0d", nm, got);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Burst vectors: div=4, len=3; div_cfg, run_req and a second
    // burst_start are changed mid-burst and must all be ignored.
    burst_tbl[0]  = '{run:0, halt:0, step:0, bs:1, bl:16'd3, dv:16'd4, et:0, es:2'd3};
    burst_tbl[1]  = '{run:0, halt:0, step:0, bs:0, bl:16'd3, dv:16'd4, et:0, es:2'd3};
    burst_tbl[2]  = '{run:1, halt:0, step:0, bs:0, bl:16'd3, dv:16'd1, et:0, es:2'd3};
    burst_tbl[3]  = '{run:1, halt:0, step:0, bs:0, bl:16'd3, dv:16'd1, et:0, es:2'd3};
    burst_tbl[4]  = '{run:1, halt:0, step:0, bs:0, bl:16'd3, dv:16'd1, et:1, es:2'd3};
    burst_tbl[5]  = '{run:1, halt:0, step:0, bs:0, bl:16'd3, dv:16'd1, et:0, es:2'd3};
    burst_tbl[6]  = '{run:0, halt:0, step:0, bs:1, bl:16'd7, dv:16'd1, et:0, es:2'd3};
    burst_tbl[7]  = '{run:0, halt:0, step:0, bs:0, bl:16'd3, dv:16'd1, et:0, es:2'd3};
    burst_tbl[8]  = '{run:0, halt:0, step:0, bs:0, bl:16'd3, dv:16'd1, et:1, es:2'd3};
    burst_tbl[9]  = '{run:0, halt:0, step:0, bs:0, bl:16'd3, dv:16'd1, et:0, es:2'd3};
    burst_tbl[10] = '{run:0, halt:0, step:0, bs:0, bl:16'd3, dv:16'd1, et:0, es:2'd3};
    burst_tbl[11] = '{run:0, halt:0, step:0, bs:0, bl:16'd3, dv:16'd1, et:0, es:2'd3};
    burst_tbl[12] = '{run:0, halt:0, step:0, bs:0, bl:16'd3, dv:16'd1, et:1, es:2'd0};
    burst_tbl[13] = '{run:0, halt:0, step:0, bs:0, bl:16'd3, dv:16'd1, et:0, es:2'd0};
    burst_tbl[14] = '{run:0, halt:0, step:0, bs:1, bl:16'd0, dv:16'd4, et:0, es:2'd0};
    burst_tbl[15] = '{run:0, halt:0, step:0, bs:0, bl:16'd0, dv:16'd4, et:0, es:2'd0};
    burst_tbl[16] = '{run:0, halt:0, step:0, bs:0, bl:16'd0, dv:16'd4, et:0, es:2'd0};

    // Reset for 10 cycles, then idle with everything quiet.
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, 16'd0, 16'd0, 0, 2'd0, "reset");
    idle(3, "post_reset");

    // Free-run at period 5; div_cfg changed mid-run must have no effect.
    cyc(0, 1, 0, 0, 0, 16'd0, 16'd5, 0, 2'd1, "run5_enter");
    for (int k = 1; k <= 25; k++)
      cyc(0, 1, 0, 0, 0, 16'd0, (k > 10) ? 16'd2 : 16'd5, (k % 5) == 0, 2'd1, "run5");
    cyc(0, 0, 0, 0, 0, 16'd0, 16'd5, 0, 2'd0, "run5_drop");
    idle(3, "run5_after");
    chk_val("run5_count", tick_count, 32'd5);
    chk_val("run5_slow", {31'd0, clk_slow}, 32'd1);

    // div_cfg=0 means period 1: tick on every RUN edge.
    cyc(0, 1, 0, 0, 0, 16'd0, 16'd0, 0, 2'd1, "run1_enter");
    for (int k = 1; k <= 8; k++) cyc(0, 1, 0, 0, 0, 16'd0, 16'd0, 1, 2'd1, "run1");
    cyc(0, 0, 0, 0, 0, 16'd0, 16'd0, 0, 2'd0, "run1_drop");
    chk_val("run1_count", tick_count, 32'd13);

    // Table-driven burst vectors.
    for (int i = 0; i < 17; i++)
      cyc(0, burst_tbl[i].run, burst_tbl[i].halt, burst_tbl[i].step, burst_tbl[i].bs,
          burst_tbl[i].bl, burst_tbl[i].dv, burst_tbl[i].et, burst_tbl[i].es, "burst_tbl");
    chk_val("burst_count", tick_count, 32'd16);

    // Held pushbutton: one tick, visible after the third sampling edge.
    for (int i = 1; i <= 50; i++)
      cyc(0, 0, 0, 1, 0, 16'd0, 16'd0, i == 3, (i == 3) ? 2'd2 : 2'd0, "step_hold");
    idle(4, "step_release");
    chk_val("step_count", tick_count, 32'd17);

    // Step pulse during RUN is dropped; RUN then ended by halt_req.
    cyc(0, 1, 0, 0, 0, 16'd0, 16'd3, 0, 2'd1, "run3_enter");
    for (int k = 1; k <= 8; k++)
      cyc(0, 1, 0, k == 1, 0, 16'd0, 16'd3, (k % 3) == 0, 2'd1, "run3_step");
    cyc(0, 1, 1, 0, 0, 16'd0, 16'd3, 0, 2'd0, "run3_halt");
    idle(4, "run3_after");
    chk_val("run3_count", tick_count, 32'd19);

    // Halt mid-burst after 4 ticks, then halt beating a burst_start in IDLE.
    cyc(0, 0, 0, 0, 1, 16'd10, 16'd2, 0, 2'd3, "halt_burst_enter");
    for (int k = 1; k <= 8; k++)
      cyc(0, 0, 0, 0, 0, 16'd10, 16'd2, (k % 2) == 0, 2'd3, "halt_burst");
    cyc(0, 0, 1, 0, 0, 16'd10, 16'd2, 0, 2'd0, "halt_burst_halt");
    cyc(0, 0, 1, 0, 1, 16'd5, 16'd2, 0, 2'd0, "halt_beats_burst");
    idle(4, "halt_after");
    chk_val("halt_count", tick_count, 32'd23);

    // Same burst, aborted by reset instead.
    cyc(0, 0, 0, 0, 1, 16'd10, 16'd2, 0, 2'd3, "rst_burst_enter");
    for (int k = 1; k <= 8; k++)
      cyc(0, 0, 0, 0, 0, 16'd10, 16'd2, (k % 2) == 0, 2'd3, "rst_burst");
    cyc(1, 0, 0, 0, 0, 16'd10, 16'd2, 0, 2'd0, "rst_burst_rst");
    idle(4, "rst_after");
    chk_val("rst_count", tick_count, 32'd0);
    chk_val("rst_slow", {31'd0, clk_slow}, 32'd0);

    // Step edge and burst_start on the same edge: burst wins, step is lost.
    cyc(0, 0, 0, 1, 0, 16'd0, 16'd1, 0, 2'd0, "step_vs_burst");
    cyc(0, 0, 0, 1, 0, 16'd0, 16'd1, 0, 2'd0, "step_vs_burst");
    cyc(0, 0, 0, 1, 1, 16'd1, 16'd1, 0, 2'd3, "step_vs_burst_go");
    cyc(0, 0, 0, 1, 0, 16'd1, 16'd1, 1, 2'd0, "step_vs_burst_tk");
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 16'd1, 16'd1, 0, 2'd0, "step_vs_burst");
    idle(3, "final_idle");
    chk_val("final_count", tick_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
